color_match_game_ctrl: RTL and testbench



---
 rtl/color_match_pkg.sv | 35 +++
 rtl/color_match_game_ctrl_timer.sv | 19 +
 rtl/color_match_game_ctrl.sv | 129 ++++++++++++
 tb/tb_color_match_game_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/color_match_pkg.sv
// color_match_pkg: shared encodings, pair map and cursor scan helper for the colour-match game.
package color_match_pkg;
    typedef enum logic [1:0] {
        ACT_HIDDEN = 2'b00,
        ACT_CURSOR = 2'b01,
        ACT_REVEAL = 2'b10,
        ACT_CLEAR  = 2'b11
    } act_e;

    typedef enum logic [1:0] {
        CARD_HIDDEN   = 2'b00,
        CARD_REVEALED = 2'b10,
        CARD_MATCHED  = 2'b11
    } card_e;

    typedef enum logic [2:0] {PICK1, PICK2, SHOW, RESOLVE, WIN} state_e;

    localparam int NUM_PAIRS = 4;
    // pair id of square i lives at [2i+:2]: {0,6} red, {1,4} green, {2,3} blue, {5,7} white
    localparam logic [15:0] PAIR_ID = {2'd3, 2'd0, 2'd3, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0};

    function automatic logic [1:0] pair_of(input logic [2:0] idx);
        return PAIR_ID[{idx, 1'b0} +: 2];
    endfunction

    // nearest non-matched square in the given direction, or cur when none exists
    function automatic logic [2:0] scan(input logic [2:0] cur, input logic [7:0] matched, input logic up);
        logic [2:0] idx;
        scan = cur;
        for (int k = 7; k >= 1; k--) begin
            idx = up ? cur + 3'(k) : cur - 3'(k);
            if (!matched[idx]) scan = idx;
        end
    endfunction
endpackage

// File: rtl/color_match_game_ctrl_timer.sv
// cm_hold_timer: loadable down-counter that reports done once it has reached zero.
module cm_hold_timer #(
    parameter int HOLD_CYCLES = 25000000,
    parameter int HOLD_W      = 25
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic done_o
);
    logic [HOLD_W-1:0] cnt_q;

    always_ff @(posedge clk_i)
        if (rst_i) cnt_q <= '0;
        else if (load_i) cnt_q <= HOLD_W'(HOLD_CYCLES - 1);
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;

    assign done_o = cnt_q == '0;
endmodule

// File: rtl/color_match_game_ctrl.sv
// color_match_game_ctrl: cursor/pick/reveal/resolve controller for the 8-square colour-match game.
// Define ATTEMPT_COUNTER_EN to count second picks on attempts (saturating); otherwise attempts is 0.
module color_match_game_ctrl
    import color_match_pkg::*;
#(
    parameter int HOLD_CYCLES = 25000000,
    parameter int HOLD_W      = 25
) (
    input  logic       clk25MHz,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    output logic [1:0] action0,
    output logic [1:0] action1,
    output logic [1:0] action2,
    output logic [1:0] action3,
    output logic [1:0] action4,
    output logic [1:0] action5,
    output logic [1:0] action6,
    output logic [1:0] action7,
    output logic       winscreen,
    output logic [7:0] attempts
);
    state_e      state_q, state_d;
    card_e       card_q [8];
    card_e       card_d [8];
    logic [2:0]  cursor_q, cursor_d, pick0_q, pick0_d, match_cnt_q, match_cnt_d;
    logic [7:0]  matched, matched_new;
    logic [15:0] act_q, act_d;
    logic        win_q, win_d, load, done;

    cm_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES), .HOLD_W(HOLD_W)) u_timer (
        .clk_i (clk25MHz),
        .rst_i (rst),
        .load_i(load),
        .done_o(done)
    );

    always_ff @(posedge clk25MHz)
        if (rst) begin
            state_q     <= PICK1;
            card_q      <= '{default: CARD_HIDDEN};
            cursor_q    <= '0;
            pick0_q     <= '0;
            match_cnt_q <= '0;
            act_q       <= 16'h0001;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            card_q      <= card_d;
            cursor_q    <= cursor_d;
            pick0_q     <= pick0_d;
            match_cnt_q <= match_cnt_d;
            act_q       <= act_d;
            win_q       <= win_d;
        end

    always_comb begin
        matched = '0;
        for (int i = 0; i < 8; i++) matched[i] = card_q[i] == CARD_MATCHED;
        matched_new = matched | (8'd1 << pick0_q) | (8'd1 << cursor_q);
    end

    always_comb begin
        state_d     = state_q;
        card_d      = card_q;
        cursor_d    = cursor_q;
        pick0_d     = pick0_q;
        match_cnt_d = match_cnt_q;
        load        = 1'b0;
        // sel wins over moves; left+right together cancel
        if ((state_q == PICK1 || state_q == PICK2) && !btn_sel && (btn_left ^ btn_right))
            cursor_d = scan(cursor_q, matched, btn_right);
        case (state_q)
            PICK1:
                if (btn_sel && card_q[cursor_q] == CARD_HIDDEN) begin
                    card_d[cursor_q] = CARD_REVEALED;
                    pick0_d = cursor_q;
                    state_d = PICK2;
                end
            PICK2:
                if (btn_sel && card_q[cursor_q] == CARD_HIDDEN) begin
                    card_d[cursor_q] = CARD_REVEALED;
                    load = 1'b1;
                    state_d = SHOW;
                end
            SHOW: state_d = done ? RESOLVE : SHOW;
            RESOLVE:
                if (pair_of(pick0_q) == pair_of(cursor_q)) begin
                    card_d[pick0_q]  = CARD_MATCHED;
                    card_d[cursor_q] = CARD_MATCHED;
                    match_cnt_d = match_cnt_q + 3'd1;
                    state_d = match_cnt_q == 3'(NUM_PAIRS - 1) ? WIN : PICK1;
                    cursor_d = scan(cursor_q, matched_new, 1'b1);
                end else begin
                    card_d[pick0_q]  = CARD_HIDDEN;
                    card_d[cursor_q] = CARD_HIDDEN;
                    state_d = PICK1;
                end
            WIN: state_d = WIN;
            default: state_d = PICK1;
        endcase
    end

    always_comb begin
        win_d = state_q == WIN;
        act_d = '0;
        for (int i = 0; i < 8; i++)
            act_d[2*i +: 2] = (win_d || card_q[i] == CARD_MATCHED) ? ACT_CLEAR :
                              card_q[i] == CARD_REVEALED ? ACT_REVEAL :
                              3'(i) == cursor_q ? ACT_CURSOR : ACT_HIDDEN;
    end

    assign {action7, action6, action5, action4, action3, action2, action1, action0} = act_q;
    assign winscreen = win_q;

`ifdef ATTEMPT_COUNTER_EN
    logic [7:0] attempts_q;

    always_ff @(posedge clk25MHz)
        if (rst) attempts_q <= '0;
        else if (state_q == PICK2 && state_d == SHOW && attempts_q != 8'hFF) attempts_q <= attempts_q + 8'd1;

    assign attempts = attempts_q;
`else
    assign attempts = 8'd0;
`endif
endmodule

// File: tb/tb_color_match_game_ctrl.sv
// tb_color_match_game_ctrl: directed vector table plus hand-timed reveal/resolve and reset sequences.
module tb_color_match_game_ctrl;
    logic clk = 1'b0, rst = 1'b1, bl = 1'b0, br = 1'b0, bs = 1'b0;
    logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic       win;
    logic [7:0] att;
    logic [15:0] acts;
    int total = 0, bad = 0;

`ifdef ATTEMPT_COUNTER_EN
    localparam bit ATT_ON = 1'b1;
`else
    localparam bit ATT_ON = 1'b0;
`endif

    typedef struct {
        logic l, r, s;
        int n;
        logic [15:0] act;
        logic win;
        logic [7:0] att;
    } vec_t;
    vec_t v [28];

    color_match_game_ctrl #(.HOLD_CYCLES(4), .HOLD_W(3)) dut (
        .clk25MHz(clk), .rst(rst), .btn_left(bl), .btn_right(br), .btn_sel(bs),
        .action0(a0), .action1(a1), .action2(a2), .action3(a3),
        .action4(a4), .action5(a5), .action6(a6), .action7(a7),
        .winscreen(win), .attempts(att)
    );

    always #5 clk = ~clk;
    assign acts = {a7, a6, a5, a4, a3, a2, a1, a0};

    function automatic logic [15:0] a(input int i, input logic [1:0] c);
        return 16'(c) << (2 * i);
    endfunction

    function automatic vec_t mk(input logic l, r, s, input int n, input logic [15:0] act, input logic w, input logic [7:0] at);
        vec_t t;
        t.l = l; t.r = r; t.s = s; t.n = n; t.act = act; t.win = w; t.att = at;
        return t;
    endfunction

    task automatic check(input string name, input logic [15:0] ea, input logic ew, input logic [7:0] eat);
        logic [7:0] xat;
        xat = ATT_ON ? eat : 8'd0;
        total++;
        if (acts !== ea) begin bad++; $display("FAIL %s actions got %h want %h", name, acts, ea); end
        total++;
        if (win !== ew) begin bad++; $display("FAIL %s winscreen got %b want %b", name, win, ew); end
        total++;
        if (att !== xat) begin bad++; $display("FAIL %s attempts got %0d want %0d", name, att, xat); end
    endtask

    task automatic step(input logic l, r, s, input int n);
        bl = l; br = r; bs = s;
        @(posedge clk); #1;
        bl = 1'b0; br = 1'b0; bs = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(v[i].l, v[i].r, v[i].s, v[i].n);
            check($sformatf("vec%0d", i), v[i].act, v[i].win, v[i].att);
        end
    endtask

    initial begin
        logic [15:0] m, m2, m3;
        m  = a(0, 3) | a(6, 3);
        m2 = m | a(2, 3) | a(3, 3);
        m3 = m2 | a(1, 3) | a(4, 3);
        v[0] = mk(0, 0, 0, 1, a(0, 1), 0, 0);
        v[1] = mk(1, 0, 0, 1, a(7, 1), 0, 0);
        v[2] = mk(0, 1, 0, 1, a(0, 1), 0, 0);
        v[3] = mk(1, 1, 0, 1, a(0, 1), 0, 0);
        v[4] = mk(0, 0, 1, 1, a(0, 2), 0, 0);
        v[5] = mk(0, 0, 1, 1, a(0, 2), 0, 0);
        for (int k = 1; k <= 6; k++) v[5 + k] = mk(0, 1, 0, 1, a(0, 2) | a(k, 1), 0, 0);
        v[12] = mk(0, 1, 0, 1, m | a(1, 1), 0, 1);
        v[13] = mk(0, 0, 1, 1, m | a(1, 2), 0, 1);
        v[14] = mk(0, 1, 0, 1, m | a(1, 2) | a(2, 1), 0, 1);
        v[15] = mk(0, 0, 1, 1, m | a(2, 2), 0, 2);
        v[16] = mk(0, 1, 0, 1, m | a(2, 2) | a(3, 1), 0, 2);
        v[17] = mk(0, 0, 1, 6, m2 | a(4, 1), 0, 3);
        v[18] = mk(1, 0, 0, 1, m2 | a(1, 1), 0, 3);
        v[19] = mk(0, 0, 1, 1, m2 | a(1, 2), 0, 3);
        v[20] = mk(0, 1, 0, 1, m2 | a(1, 2) | a(4, 1), 0, 3);
        v[21] = mk(0, 0, 1, 6, m3 | a(5, 1), 0, 4);
        v[22] = mk(0, 0, 1, 1, m3 | a(5, 2), 0, 4);
        v[23] = mk(0, 1, 0, 1, m3 | a(5, 2) | a(7, 1), 0, 4);
        v[24] = mk(0, 0, 1, 6, 16'hFFFF, 1, 5);
        v[25] = mk(1, 0, 0, 1, 16'hFFFF, 1, 5);
        v[26] = mk(0, 0, 1, 1, 16'hFFFF, 1, 5);
        v[27] = mk(0, 1, 0, 3, 16'hFFFF, 1, 5);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run(0, 11);

        // matching pair 0/6: revealed through SHOW and RESOLVE, then cleared with cursor moved on
        bs = 1'b1;
        @(posedge clk); #1 bs = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("match_show%0d", c), a(0, 2) | a(6, 2), 0, 1);
        end
        @(posedge clk); #1;
        check("match_done", m | a(7, 1), 0, 1);

        run(12, 14);

        // mismatch 1/2 using sel+right, with buttons mashed during SHOW
        bs = 1'b1; br = 1'b1;
        @(posedge clk); #1;
        br = 1'b0; bs = 1'b1; bl = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 3) begin bs = 1'b0; bl = 1'b0; end
            check($sformatf("miss_show%0d", c), m | a(1, 2) | a(2, 2), 0, 2);
        end
        @(posedge clk); #1;
        check("miss_done", m | a(2, 1), 0, 2);

        run(15, 27);

        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst_from_win", a(0, 1), 0, 0);
        step(0, 0, 1, 1);
        check("rst_pick0", a(0, 2), 0, 0);
        step(0, 1, 0, 1);
        check("rst_move", a(0, 2) | a(1, 1), 0, 0);
        bs = 1'b1;
        @(posedge clk); #1 bs = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst_mid_show", a(0, 1), 0, 0);
        repeat (5) @(posedge clk);
        #1 check("rst_quiet", a(0, 1), 0, 0);
        step(0, 0, 1, 1);
        check("post_pick0", a(0, 2), 0, 0);
        step(0, 1, 0, 1);
        step(0, 0, 1, 6);
        check("post_miss", a(1, 1), 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
